// File: rtl/dot_result_buffer_pkg.sv
// rtl/dot_result_buffer_pkg.sv - UCBFloat width and DotProduct latency shared with the DotProduct wrapper
package dot_result_buffer_pkg;

  localparam int UCB_W              = 65;
  localparam int DP_LATENCY_DEFAULT = 9;

  typedef logic [UCB_W-1:0] ucb_float_t;

  function automatic int count_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/dot_result_buffer_result_fifo.sv
// rtl/dot_result_buffer_result_fifo.sv - small registered FIFO with push/pop/count/head interface
module result_fifo
  import dot_result_buffer_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int W     = 73
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          push,
  input  logic [W-1:0]                  data,
  input  logic                          pop,
  output logic [count_width(DEPTH)-1:0] count,
  output logic [W-1:0]                  head
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = count_width(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;

  // Storage is cleared too so the head reads zero out of reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= data;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/dot_result_buffer.sv
// rtl/dot_result_buffer.sv - flow control and result FIFO behind the fixed-latency DotProduct stage
module dot_result_buffer
  import dot_result_buffer_pkg::*;
#(
  parameter int DP_LATENCY = DP_LATENCY_DEFAULT,
  parameter int DEPTH      = 4,
  parameter int TAG_W      = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [TAG_W-1:0] in_tag,
  output logic             in_ready,
  output logic             proceed,
  input  logic [UCB_W-1:0] dp_out,
  output logic             out_valid,
  output logic [UCB_W-1:0] out_data,
  output logic [TAG_W-1:0] out_tag,
  input  logic             out_ready,
  output logic             busy
);

  localparam int CW = count_width(DEPTH);

  logic [DP_LATENCY-1:0] vld;
  logic [TAG_W-1:0]      tags [DP_LATENCY];
  logic [CW-1:0]         count;
  logic                  push;
  logic                  pop;
  logic [TAG_W+UCB_W-1:0] head;
  ucb_float_t            head_data;

  // Tracker mirrors the DotProduct pipeline; bubbles shift in so it drains on idle cycles.
  always_ff @(posedge clk) begin
    if (reset) begin
      vld <= '0;
      for (int k = 0; k < DP_LATENCY; k++) tags[k] <= '0;
    end else if (proceed) begin
      vld[0]  <= in_valid;
      tags[0] <= in_tag;
      for (int k = 1; k < DP_LATENCY; k++) begin
        vld[k]  <= vld[k-1];
        tags[k] <= tags[k-1];
      end
    end
  end

  // Stall only when a finished result would land in a full FIFO that is not popping.
  assign proceed  = !vld[DP_LATENCY-1] || (count < CW'(DEPTH)) || out_ready;
  assign in_ready = proceed && !reset;
  assign push     = proceed && vld[DP_LATENCY-1];
  assign pop      = out_valid && out_ready;

  result_fifo #(
    .DEPTH (DEPTH),
    .W     (TAG_W + UCB_W)
  ) u_result_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .data  ({tags[DP_LATENCY-1], dp_out}),
    .pop   (pop),
    .count (count),
    .head  (head)
  );

  assign head_data = head[UCB_W-1:0];
  assign out_data  = head_data;
  assign out_tag   = head[TAG_W+UCB_W-1:UCB_W];
  assign out_valid = (count != '0);
  assign busy      = (|vld) || out_valid;

endmodule

// File: tb/tb_dot_result_buffer.sv
// tb/tb_dot_result_buffer.sv - self-checking bench for dot_result_buffer with a DotProduct pipeline model
module tb_dot_result_buffer;
  import dot_result_buffer_pkg::*;

  localparam int L  = 9;
  localparam int D  = 4;
  localparam int TW = 8;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             in_valid = 1'b0;
  logic [TW-1:0]    in_tag = '0;
  logic             in_ready;
  logic             proceed;
  logic [UCB_W-1:0] dp_out;
  logic             out_valid;
  logic [UCB_W-1:0] out_data;
  logic [TW-1:0]    out_tag;
  logic             out_ready = 1'b1;
  logic             busy;

  int n_checks = 0;
  int n_fail   = 0;

  logic [UCB_W-1:0] model_data = '0;
  logic [UCB_W-1:0] exp_data   = '0;
  logic [UCB_W-1:0] dp_pipe [L];

  typedef struct {
    logic [TW-1:0]    tag;
    logic [UCB_W-1:0] data;
  } sb_t;
  sb_t sb [$];

  // Operands are stored in half units so the table stays integer.
  typedef struct {
    int a0, a1, a2, b0, b1, b2;
    logic [TW-1:0] tag;
    logic [63:0]   expd;
  } vec_t;
  vec_t vecs [5];

  dot_result_buffer #(.DP_LATENCY(L), .DEPTH(D), .TAG_W(TW)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_tag    (in_tag),
    .in_ready  (in_ready),
    .proceed   (proceed),
    .dp_out    (dp_out),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_tag   (out_tag),
    .out_ready (out_ready),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // Free-running DotProduct stand-in: advances on proceed, result on the tail after L edges.
  always @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < L; k++) dp_pipe[k] <= '0;
    end else if (proceed) begin
      dp_pipe[0] <= model_data;
      for (int k = 1; k < L; k++) dp_pipe[k] <= dp_pipe[k-1];
    end
  end
  assign dp_out = dp_pipe[L-1];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  function automatic logic [UCB_W-1:0] dot3(input real a0, a1, a2, b0, b1, b2);
    return {1'b0, $realtobits(a0 * b0 + a1 * b1 + a2 * b2)};
  endfunction

  task automatic drive(input logic v, input logic [TW-1:0] t,
                       input logic [UCB_W-1:0] m, input logic [UCB_W-1:0] e);
    in_valid   = v;
    in_tag     = t;
    model_data = m;
    exp_data   = e;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: push on accept, pop and compare on consume.
  always @(negedge clk) begin
    if (!reset) begin
      if (in_valid && in_ready) sb.push_back('{in_tag, exp_data});
      if (out_valid && out_ready) begin
        sb_t e;
        if (sb.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_result: got tag %0h expected no result", out_tag);
        end else begin
          e = sb.pop_front();
          check("sb_tag", out_tag, e.tag);
          check("sb_data", out_data, e.data);
        end
      end
    end
  end

  initial begin
    int n, first, last, ones, plo, acc, bad, prev, stale;
    logic [UCB_W-1:0] d;

    vecs[0] = '{2, 4, 6, 8, 10, 12, 8'h11, 64'h4040000000000000};
    vecs[1] = '{2, 2, 2, 2, 2, 2, 8'h22, 64'h4008000000000000};
    vecs[2] = '{1, 1, 0, 4, 4, 0, 8'h33, 64'h4000000000000000};
    vecs[3] = '{-2, 0, 0, 2, 0, 0, 8'h44, 64'hBFF0000000000000};
    vecs[4] = '{3, 0, 0, 2, 0, 0, 8'h55, 64'h3FF8000000000000};

    drive(1'b0, '0, '0, '0);
    tick();
    tick();
    check("rst_in_ready", in_ready, 0);
    check("rst_proceed", proceed, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_tag", out_tag, 0);
    check("rst_busy", busy, 0);
    reset = 1'b0;
    #1;
    check("idle_in_ready", in_ready, 1);

    // Single operations from the table.
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, vecs[i].tag,
            dot3(real'(vecs[i].a0) / 2.0, real'(vecs[i].a1) / 2.0, real'(vecs[i].a2) / 2.0,
                 real'(vecs[i].b0) / 2.0, real'(vecs[i].b1) / 2.0, real'(vecs[i].b2) / 2.0),
            {1'b0, vecs[i].expd});
      tick();
      drive(1'b0, '0, '0, '0);
      n = 1;
      while (!out_valid && n < 40) begin
        tick();
        n++;
      end
      check("single_latency", n, L + 1);
      check("single_tag", out_tag, vecs[i].tag);
      tick();
      check("single_busy_clear", busy, 0);
    end

    // Back-to-back stream of 16.
    first = -1; last = -1; ones = 0; plo = 0;
    for (int i = 0; i < 40; i++) begin
      if (i < 16) begin
        d = dot3(real'(i), 1.0, 0.0, 1.0, real'(i), 0.0);
        drive(1'b1, TW'(i), d, d);
      end else begin
        drive(1'b0, '0, '0, '0);
      end
      #1;
      if (!proceed) plo++;
      if (out_valid) begin
        if (first < 0) first = i;
        last = i;
        ones++;
      end
      tick();
    end
    check("stream_proceed_low_cycles", plo, 0);
    check("stream_results", ones, 16);
    check("stream_first_cycle", first, L + 1);
    check("stream_span", last - first, 15);

    // Backpressure until the pipeline stalls.
    out_ready = 1'b0;
    acc = 0;
    for (int i = 0; i < 40; i++) begin
      d = dot3(real'(i), 2.0, 0.0, 1.0, 1.0, 0.0);
      drive(1'b1, TW'(8'h40 + i), d, d);
      #1;
      if (!in_ready) break;
      acc++;
      tick();
    end
    drive(1'b0, '0, '0, '0);
    check("bp_accepted", acc, D + L);
    check("bp_stall_proceed", proceed, 0);
    check("bp_out_valid", out_valid, 1);
    check("bp_head_tag", out_tag, 8'h40);
    tick();
    tick();
    check("bp_stall_held", proceed, 0);
    check("bp_head_held", out_tag, 8'h40);

    // Full FIFO with valid tail and simultaneous pop.
    out_ready = 1'b1;
    for (int j = 0; j < 3; j++) begin
      #1;
      check("full_pop_proceed", proceed, 1);
      check("full_pop_head", out_tag, TW'(8'h40 + j));
      tick();
    end
    out_ready = 1'b0;
    #1;
    check("full_count_held", proceed, 0);
    out_ready = 1'b1;
    n = 0;
    while (busy && n < 60) begin
      tick();
      n++;
    end
    check("bp_drained", busy, 0);
    check("bp_sb_empty", sb.size(), 0);

    // Alternating bubbles.
    ones = 0; bad = 0; prev = -1;
    for (int i = 0; i < 40; i++) begin
      if (i < 12 && (i % 2) == 0) begin
        d = dot3(real'(i), 3.0, 1.0, 1.0, 1.0, 2.0);
        drive(1'b1, TW'(8'hA0 + i / 2), d, d);
      end else begin
        drive(1'b0, '0, '0, '0);
      end
      #1;
      if (out_valid) begin
        if (prev >= 0 && i - prev != 2) bad++;
        prev = i;
        ones++;
      end
      tick();
    end
    check("bubble_results", ones, 6);
    check("bubble_spacing_errors", bad, 0);

    // Reset mid-flight.
    for (int i = 0; i < 5; i++) begin
      d = dot3(real'(i), 1.0, 1.0, 1.0, 1.0, 1.0);
      drive(1'b1, TW'(8'hC0 + i), d, d);
      tick();
    end
    drive(1'b0, '0, '0, '0);
    reset = 1'b1;
    #1;
    check("midrst_in_ready", in_ready, 0);
    check("midrst_busy_before", busy, 1);
    sb.delete();
    tick();
    reset = 1'b0;
    #1;
    check("midrst_out_valid", out_valid, 0);
    check("midrst_busy", busy, 0);
    stale = 0;
    for (int i = 0; i < 30; i++) begin
      if (out_valid) stale++;
      tick();
    end
    check("midrst_no_stale", stale, 0);
    check("final_sb_empty", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
